// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM port between instruction fetch and
// the load/store unit. Each 32-bit fetch or sized load/store is split into
// byte accesses. Read bytes are reassembled little-endian.
// Optional build macro MEM_ARB_FAIR_EN: when both requesters are waiting,
// grants alternate so that fetch cannot be starved. Without it, load/store
// always has strict priority.
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_ok,
    output logic [31:0]       if_data,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_ok,
    output logic [31:0]       ls_rdata,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic              busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    // Transaction captured at grant; request inputs are not looked at again.
    typedef struct packed {
        logic              own_ls;
        logic [ADDR_W-1:0] base;
        logic [2:0]        n;
        logic [31:0]       wdata;
    } txn_t;

    logic [1:0]  state;
    txn_t        txn;
    logic [2:0]  k;         // bytes issued so far
    logic [31:0] rbuf;      // read assembly buffer
    logic [31:0] rbuf_nxt;
    logic [1:0]  cap_idx;   // byte lane that ram_din belongs to this cycle
    logic        any_req;
    logic        gnt_ls;
    logic [2:0]  ls_n;

    assign any_req = if_req | ls_req;
    assign ls_n    = (ls_size == 2'd0) ? 3'd1 : (ls_size == 2'd1) ? 3'd2 : 3'd4;
    // ram_din answers the address issued one cycle earlier, i.e. byte k-1.
    assign cap_idx = k[1:0] - 2'd1;

`ifdef MEM_ARB_FAIR_EN
    logic last_ls;

    // Remember who won the last grant so a contended grant can go to fetch.
    always_ff @(posedge clk) begin
        if (rst)
            last_ls <= 1'b0;
        else if (state == IDLE && any_req)
            last_ls <= gnt_ls;
    end

    assign gnt_ls = ls_req & ~(if_req & last_ls);
`else
    assign gnt_ls = ls_req;
`endif

    // Merge the returning RAM byte into its lane of the assembly buffer.
    always_comb begin
        rbuf_nxt = rbuf;
        rbuf_nxt[{cap_idx, 3'b000} +: 8] = ram_din;
    end

    // Main sequencer: grant, byte-serial read/write, one-cycle completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            txn      <= '0;
            k        <= '0;
            rbuf     <= '0;
            if_data  <= '0;
            ls_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        txn.own_ls <= gnt_ls;
                        txn.base   <= gnt_ls ? ls_addr : if_addr;
                        txn.n      <= gnt_ls ? ls_n : 3'd4;
                        txn.wdata  <= ls_wdata;
                        k          <= '0;
                        rbuf       <= '0;
                        state      <= (gnt_ls && ls_we) ? WR : RD;
                    end
                end
                RD: begin
                    if (!txn.own_ls && if_flush) begin
                        state <= IDLE;
                    end else begin
                        if (k != 3'd0)
                            rbuf <= rbuf_nxt;
                        if (k == txn.n) begin
                            state <= DONE;
                            if (txn.own_ls)
                                ls_rdata <= rbuf_nxt;
                            else
                                if_data <= rbuf_nxt;
                        end else begin
                            k <= k + 3'd1;
                        end
                    end
                end
                WR: begin
                    if (k == txn.n - 3'd1)
                        state <= DONE;
                    k <= k + 3'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM port drive; quiet outside active RD/WR byte cycles.
    always_comb begin
        ram_a    = '0;
        ram_wr   = 1'b0;
        ram_dout = '0;
        if (state == WR) begin
            ram_wr   = 1'b1;
            ram_a    = txn.base + ADDR_W'(k);
            ram_dout = txn.wdata[{k[1:0], 3'b000} +: 8];
        end else if (state == RD && k != txn.n) begin
            ram_a = txn.base + ADDR_W'(k);
        end
    end

    assign if_ok = (state == DONE) & ~txn.own_ls;
    assign ls_ok = (state == DONE) & txn.own_ls;
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed timing tests plus randomized request bursts.
// Expected completions and RAM writes are predicted at transaction level and
// queued; a negedge monitor pops and compares whenever the DUT reports.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, if_flush = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
    logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0;
    logic [1:0]  ls_size = '0;
    logic        if_ok, ls_ok, ram_wr, busy;
    logic [31:0] if_data, ls_rdata, ram_a;
    logic [7:0]  ram_din = '0, ram_dout;

`ifdef MEM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_ok(if_ok), .if_data(if_data),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_ok(ls_ok), .ls_rdata(ls_rdata),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a),
        .ram_wr(ram_wr), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          own_ls;
        bit          we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } tr_t;
    typedef struct { bit own_ls; bit st; logic [31:0] data; } exp_t;
    typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;

    exp_t        expq[$];
    wr_t         wq[$];
    logic [7:0]  mem[logic [31:0]];
    logic [7:0]  ref_mem[logic [31:0]];
    bit          last_ls = 1'b0;
    int          checks = 0, failures = 0;
    logic        poke_en = 1'b0;
    logic [31:0] poke_a = '0;
    logic [7:0]  poke_d = '0;

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[31:24] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : dflt(a);
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // RAM model: registered read, one-cycle latency; writes on ram_wr.
    always @(posedge clk) begin
        if (poke_en)
            mem[poke_a] = poke_d;
        else if (ram_wr === 1'b1)
            mem[ram_a] = ram_dout;
        ram_din <= $isunknown(ram_a) ? 8'h00 : ram_byte(ram_a);
    end

    // Monitor: compare every completion and every RAM write against queues.
    always @(negedge clk) begin
        exp_t e;
        wr_t  w;
        if (if_ok === 1'b1 || ls_ok === 1'b1) begin
            chk("ok_exclusive", 32'(if_ok & ls_ok), 32'd0);
            if (expq.size() == 0) begin
                chk("unexpected_ok", 32'({if_ok, ls_ok}), 32'd0);
            end else begin
                e = expq.pop_front();
                chk("ok_owner", 32'(ls_ok), 32'(e.own_ls));
                if (!e.st)
                    chk(e.own_ls ? "ls_rdata" : "if_data",
                        e.own_ls ? ls_rdata : if_data, e.data);
            end
        end
        if (ram_wr === 1'b1) begin
            if (wq.size() == 0) begin
                chk("unexpected_write", ram_a, 32'hFFFF_FFFF);
            end else begin
                w = wq.pop_front();
                chk("wr_addr", ram_a, w.a);
                chk("wr_data", 32'(ram_dout), 32'(w.d));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        poke_a = a; poke_d = d; poke_en = 1'b1;
        step();
        poke_en = 1'b0;
        ref_mem[a] = d;
    endtask

    function automatic int nbytes(input tr_t t);
        if (!t.own_ls)       return 4;
        if (t.size == 2'd0)  return 1;
        if (t.size == 2'd1)  return 2;
        return 4;
    endfunction

    // Transaction-level outcome: bytes read from / written to the model RAM.
    task automatic predict(input tr_t t);
        exp_t        e;
        wr_t         w;
        logic [31:0] a;
        int          n;
        n = nbytes(t);
        e.own_ls = t.own_ls;
        e.st     = t.own_ls && t.we;
        e.data   = '0;
        for (int i = 0; i < n; i++) begin
            a = t.addr + 32'(i);
            if (e.st) begin
                w.a = a; w.d = t.wdata[8*i +: 8];
                wq.push_back(w);
                ref_mem[a] = w.d;
            end else begin
                e.data[8*i +: 8] = ref_byte(a);
            end
        end
        expq.push_back(e);
    endtask

    function automatic tr_t rnd_tr(input bit ls);
        tr_t t;
        t.own_ls = ls;
        t.we     = ls ? 1'($urandom_range(0, 1)) : 1'b0;
        t.size   = ls ? 2'($urandom_range(0, 3)) : 2'd2;
        if (ls)
            t.addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                                 : 32'h2000 + 32'($urandom_range(0, 15));
        else
            t.addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC
                                                 : 32'h100 + 32'(4 * $urandom_range(0, 3));
        t.wdata = $urandom;
        return t;
    endfunction

    task automatic load_if(input tr_t t);
        if_req = 1'b1; if_addr = t.addr;
    endtask

    task automatic load_ls(input tr_t t);
        ls_req = 1'b1; ls_we = t.we; ls_size = t.size; ls_addr = t.addr; ls_wdata = t.wdata;
    endtask

    // Both requesters start together and reload their next request at ok.
    task automatic run_burst(input int ni, input int nl);
        tr_t iq[$];
        tr_t lq[$];
        int  a, b, bud;
        bit  pick_ls;
        for (int i = 0; i < ni; i++) iq.push_back(rnd_tr(1'b0));
        for (int i = 0; i < nl; i++) lq.push_back(rnd_tr(1'b1));
        a = 0; b = 0;
        while (a < ni || b < nl) begin
            pick_ls = (b < nl) && (a >= ni || !(FAIR && last_ls));
            if (pick_ls) begin predict(lq[b]); b++; end
            else         begin predict(iq[a]); a++; end
            last_ls = pick_ls;
        end
        if (iq.size() > 0) load_if(iq[0]);
        if (lq.size() > 0) load_ls(lq[0]);
        bud = 0;
        while ((iq.size() > 0 || lq.size() > 0) && bud < 3000) begin
            step();
            bud++;
            if (if_ok === 1'b1 && iq.size() > 0) begin
                void'(iq.pop_front());
                if (iq.size() > 0) load_if(iq[0]); else if_req = 1'b0;
            end
            if (ls_ok === 1'b1 && lq.size() > 0) begin
                void'(lq.pop_front());
                if (lq.size() > 0) load_ls(lq[0]); else ls_req = 1'b0;
            end
        end
        if (bud >= 3000) chk("burst_timeout", 32'(bud), 32'd0);
        if_req = 1'b0; ls_req = 1'b0;
        step(); step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tr_t t;
        int  ni, nl;

        // Reset state
        step(); step(); step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_if_ok", 32'(if_ok), 0);
        chk("rst_ls_ok", 32'(ls_ok), 0);
        chk("rst_ram_wr", 32'(ram_wr), 0);
        chk("rst_ram_a", ram_a, 0);
        chk("rst_ram_dout", 32'(ram_dout), 0);
        chk("rst_if_data", if_data, 0);
        chk("rst_ls_rdata", ls_rdata, 0);
        rst = 1'b0;
        step();

        // Word fetch timing
        poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h10); poke(32'h103, 8'h00);
        t = '{own_ls: 1'b0, we: 1'b0, size: 2'd2, addr: 32'h100, wdata: 32'h0};
        predict(t);
        load_if(t);
        for (int c = 1; c <= 4; c++) begin
            step();
            chk("fetch_ram_a", ram_a, 32'h100 + 32'(c - 1));
            chk("fetch_busy", 32'(busy), 1);
        end
        step();
        chk("fetch_ok_c5", 32'(if_ok), 0);
        step();
        chk("fetch_ok_c6", 32'(if_ok), 1);
        chk("fetch_data", if_data, 32'h0010_0513);
        if_req = 1'b0;
        step();
        chk("fetch_idle", 32'(busy), 0);

        // Byte store
        t = '{own_ls: 1'b1, we: 1'b1, size: 2'd0, addr: 32'h2001, wdata: 32'hAABB_CCDD};
        predict(t);
        load_ls(t);
        step();
        chk("bst_wr", 32'(ram_wr), 1);
        chk("bst_a", ram_a, 32'h2001);
        chk("bst_dout", 32'(ram_dout), 32'hDD);
        step();
        chk("bst_ok", 32'(ls_ok), 1);
        chk("bst_wr_off", 32'(ram_wr), 0);
        ls_req = 1'b0;
        step();

        // Half load across the address wrap
        poke(32'hFFFF_FFFF, 8'h34); poke(32'h0, 8'h12);
        t = '{own_ls: 1'b1, we: 1'b0, size: 2'd1, addr: 32'hFFFF_FFFF, wdata: 32'h0};
        predict(t);
        load_ls(t);
        step(); chk("hld_a0", ram_a, 32'hFFFF_FFFF);
        step(); chk("hld_a1", ram_a, 32'h0);
        step(); chk("hld_ok_c3", 32'(ls_ok), 0);
        step(); chk("hld_ok_c4", 32'(ls_ok), 1);
        chk("hld_data", ls_rdata, 32'h0000_1234);
        ls_req = 1'b0;
        step();

        // Flush during fetch
        t = '{own_ls: 1'b0, we: 1'b0, size: 2'd2, addr: 32'h40, wdata: 32'h0};
        load_if(t);
        step(); step(); step();
        if_flush = 1'b1;
        step();
        chk("flush_busy", 32'(busy), 0);
        chk("flush_ram_a", ram_a, 0);
        chk("flush_ok", 32'(if_ok), 0);
        if_flush = 1'b0; if_req = 1'b0;
        step();
        chk("flush_ok_late", 32'(if_ok), 0);
        chk("flush_keep_data", if_data, 32'h0010_0513);

        // Reset in the middle of a word store
        t = '{own_ls: 1'b1, we: 1'b1, size: 2'd2, addr: 32'h3000, wdata: 32'h1122_3344};
        wq.push_back('{a: 32'h3000, d: 8'h44}); ref_mem[32'h3000] = 8'h44;
        wq.push_back('{a: 32'h3001, d: 8'h33}); ref_mem[32'h3001] = 8'h33;
        load_ls(t);
        step();
        step();
        rst = 1'b1; ls_req = 1'b0;
        step();
        chk("rstw_wr", 32'(ram_wr), 0);
        chk("rstw_ok", 32'(ls_ok), 0);
        chk("rstw_busy", 32'(busy), 0);
        chk("rstw_ram_a", ram_a, 0);
        chk("rstw_if_data", if_data, 0);
        chk("rstw_ls_rdata", ls_rdata, 0);
        rst = 1'b0;
        last_ls = 1'b0;
        step();
        chk("rstw_ok_late", 32'(ls_ok), 0);

        // Contention: equal and lopsided demand, then random bursts
        run_burst(2, 2);
        run_burst(1, 3);
        run_burst(3, 1);
        for (int i = 0; i < 30; i++) begin
            ni = $urandom_range(0, 3);
            nl = $urandom_range(0, 3);
            if (ni + nl == 0) nl = 1;
            run_burst(ni, nl);
        end

        chk("expq_drained", 32'(expq.size()), 0);
        chk("wq_drained", 32'(wq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
